// File: rtl/hex_dump_uart_if.sv
`default_nettype none
// ============================================================================
// Module   : hex_dump_uart_if
// Purpose  : Start/data request plus valid/ready character stream of the
//            hex dumper.
// Revision : 1.0 - initial release
// ============================================================================
interface hex_dump_uart_if #(
    parameter int DATA_W = 96
) ();
    logic              start;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              done;

    // master = the dumper (character source); slave = requester / UART side
    modport master (
        input  start, data, tx_ready,
        output busy, tx_data, tx_valid, done
    );
    modport slave (
        output start, data, tx_ready,
        input  busy, tx_data, tx_valid, done
    );
endinterface
`default_nettype wire

// File: rtl/hex_dump_uart.sv
`default_nettype none
// ============================================================================
// Module   : hex_dump_uart
// Purpose  : Triggered frame generator dumping a wide word as ASCII hex over
//            a valid/ready byte stream, with optional separators and CR/LF.
// Revision : 1.0 - initial release
// ============================================================================
module hex_dump_uart #(
    parameter int         DATA_W        = 96,
    parameter int         GROUP_NIBBLES = 8,
    parameter logic [7:0] SEP_CHAR      = 8'h20,
    parameter bit         UPPERCASE     = 1'b1,
    parameter bit         EOL_CR        = 1'b1,
    parameter bit         EOL_LF        = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    hex_dump_uart_if.master bus
);
    localparam int         c_NIBS  = DATA_W / 4;
    localparam int         c_IDX_W = (c_NIBS > 1) ? $clog2(c_NIBS) : 1;
    localparam int         c_GRP_W = (GROUP_NIBBLES > 0) ? $clog2(GROUP_NIBBLES + 1) : 1;
    localparam logic [7:0] c_CR    = 8'h0D;
    localparam logic [7:0] c_LF    = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NIB  = 3'd1,
        S_SEP  = 3'd2,
        S_CR   = 3'd3,
        S_LF   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_snap;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_GRP_W-1:0]  r_grp;
    logic                r_busy;
    logic                r_tx_valid;
    logic [7:0]          r_tx_data;
    logic                r_done;

    logic                w_hs;
    logic [c_IDX_W-1:0]  w_idx_dec;
    logic [c_GRP_W-1:0]  w_grp_inc;
    logic                w_grp_full;
    logic [7:0]          w_next_char;
    logic [7:0]          w_first_char;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    assign w_hs         = r_tx_valid & bus.tx_ready;
    assign w_idx_dec    = r_idx - c_IDX_W'(1);
    assign w_grp_inc    = r_grp + c_GRP_W'(1);
    assign w_grp_full   = (GROUP_NIBBLES > 0) && (w_grp_inc == c_GRP_W'(GROUP_NIBBLES));
    // Characters are prepared one step ahead so the stream has no bubbles
    assign w_next_char  = hex_char(r_snap[{w_idx_dec, 2'b00} +: 4]);
    assign w_first_char = hex_char(bus.data[DATA_W-1 -: 4]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_snap     <= '0;
            r_idx      <= '0;
            r_grp      <= '0;
            r_busy     <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_snap     <= bus.data;
                        r_idx      <= c_IDX_W'(c_NIBS - 1);
                        r_grp      <= '0;
                        r_busy     <= 1'b1;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= w_first_char;
                        r_state    <= S_NIB;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_NIB: begin
                    if (w_hs) begin
                        if (r_idx == '0) begin
                            if (EOL_CR) begin
                                r_state   <= S_CR;
                                r_tx_data <= c_CR;
                            end else if (EOL_LF) begin
                                r_state   <= S_LF;
                                r_tx_data <= c_LF;
                            end else begin
                                r_state    <= S_DONE;
                                r_busy     <= 1'b0;
                                r_tx_valid <= 1'b0;
                                r_tx_data  <= 8'h00;
                                r_done     <= 1'b1;
                            end
                        end else if (w_grp_full) begin
                            r_state   <= S_SEP;
                            r_grp     <= '0;
                            r_tx_data <= SEP_CHAR;
                        end else begin
                            r_idx     <= w_idx_dec;
                            r_grp     <= w_grp_inc;
                            r_tx_data <= w_next_char;
                        end
                    end
                end
                S_SEP: begin
                    if (w_hs) begin
                        r_idx     <= w_idx_dec;
                        r_state   <= S_NIB;
                        r_tx_data <= w_next_char;
                    end
                end
                S_CR: begin
                    if (w_hs) begin
                        if (EOL_LF) begin
                            r_state   <= S_LF;
                            r_tx_data <= c_LF;
                        end else begin
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_tx_valid <= 1'b0;
                            r_tx_data  <= 8'h00;
                            r_done     <= 1'b1;
                        end
                    end
                end
                S_LF: begin
                    if (w_hs) begin
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_tx_valid <= 1'b0;
                        r_tx_data  <= 8'h00;
                        r_done     <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_data  = r_tx_data;
    assign bus.done     = r_done;
endmodule
`default_nettype wire

// File: tb/tb_hex_dump_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_dump_uart
// Purpose  : Directed self-checking bench for three hex_dump_uart variants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_dump_uart;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic        start_drv;
    logic        ready_drv;
    logic [95:0] data_drv;
    int          total = 0;
    int          bad   = 0;

    localparam logic [95:0] c_D0 = 96'h123456789abcdef123456789;
    localparam string       c_E0 = "12345678 9ABCDEF1 23456789\015\012";

    always #5 clk = ~clk;

    hex_dump_uart_if #(.DATA_W(96)) if0 ();
    hex_dump_uart_if #(.DATA_W(16)) if1 ();
    hex_dump_uart_if #(.DATA_W(4))  if2 ();

    assign if0.start    = start_drv && (sel == 2'd0);
    assign if1.start    = start_drv && (sel == 2'd1);
    assign if2.start    = start_drv && (sel == 2'd2);
    assign if0.data     = data_drv;
    assign if1.data     = data_drv[15:0];
    assign if2.data     = data_drv[3:0];
    assign if0.tx_ready = ready_drv;
    assign if1.tx_ready = ready_drv;
    assign if2.tx_ready = ready_drv;

    hex_dump_uart #(.DATA_W(96)) u0 (.clk(clk), .rst(rst), .bus(if0.master));
    hex_dump_uart #(.DATA_W(16), .GROUP_NIBBLES(0), .UPPERCASE(1'b0), .EOL_CR(1'b0))
        u1 (.clk(clk), .rst(rst), .bus(if1.master));
    hex_dump_uart #(.DATA_W(4), .UPPERCASE(1'b1))
        u2 (.clk(clk), .rst(rst), .bus(if2.master));

    logic [7:0] obs_data;
    logic       obs_valid, obs_busy, obs_done;
    always_comb begin
        case (sel)
            2'd0:    begin obs_data = if0.tx_data; obs_valid = if0.tx_valid; obs_busy = if0.busy; obs_done = if0.done; end
            2'd1:    begin obs_data = if1.tx_data; obs_valid = if1.tx_valid; obs_busy = if1.busy; obs_done = if1.done; end
            default: begin obs_data = if2.tx_data; obs_valid = if2.tx_valid; obs_busy = if2.busy; obs_done = if2.done; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start at a negedge; data is trashed right after capture
    task automatic start_frame(input logic [1:0] s, input logic [95:0] d);
        sel       = s;
        data_drv  = d;
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        data_drv  = '1;
        chk("busy_rise", obs_busy, 1);
    endtask

    task automatic rcv(input string exp, input int duty, input bit repulse);
        int         n     = 0;
        int         cyc   = 0;
        bit         stall = 1'b0;
        bit         rdy;
        logic [7:0] held  = 8'h00;
        while (n < exp.len() && cyc < 2000) begin
            if (stall) begin
                chk("hold_valid", obs_valid, 1);
                chk("hold_data", obs_data, held);
            end
            if (duty >= 100) chk("no_bubble", obs_valid, 1);
            rdy       = (duty >= 100) || ($urandom_range(0, 99) < duty);
            ready_drv = rdy;
            start_drv = repulse && (n == 3 || n == 10);
            stall     = 1'b0;
            if (obs_valid) begin
                if (rdy) begin
                    chk("char", obs_data, exp[n]);
                    n++;
                end else begin
                    stall = 1'b1;
                    held  = obs_data;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start_drv = 1'b0;
        chk("frame_len", n, exp.len());
    endtask

    task automatic end_frame(input bit again, input logic [95:0] d);
        chk("done_pulse", obs_done, 1);
        chk("done_busy", obs_busy, 0);
        chk("done_valid", obs_valid, 0);
        if (again) begin
            data_drv  = d;
            start_drv = 1'b1;
        end
        @(negedge clk);
        start_drv = 1'b0;
        data_drv  = '1;
        chk("done_clear", obs_done, 0);
        chk("busy_after", obs_busy, again);
        chk("valid_after", obs_valid, again);
    endtask

    initial begin
        rst       = 1'b1;
        sel       = 2'd0;
        start_drv = 1'b0;
        ready_drv = 1'b0;
        data_drv  = '0;
        #3;
        chk("rst_valid", obs_valid, 0);
        chk("rst_busy", obs_busy, 0);
        chk("rst_done", obs_done, 0);
        chk("rst_data", obs_data, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full-rate frame with ignored re-starts, then back-to-back frame under backpressure
        start_frame(2'd0, c_D0);
        rcv(c_E0, 100, 1'b1);
        end_frame(1'b1, c_D0);
        rcv(c_E0, 30, 1'b0);
        end_frame(1'b0, '0);
        @(negedge clk);
        chk("stay_idle", obs_valid, 0);

        // Asynchronous reset after the fifth handshake
        start_frame(2'd0, c_D0);
        ready_drv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("pre_rst_char", obs_data, c_E0[i]);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", obs_valid, 0);
        chk("arst_busy", obs_busy, 0);
        chk("arst_done", obs_done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_frame(2'd0, c_D0);
        rcv(c_E0, 100, 1'b0);
        end_frame(1'b0, '0);

        // 16-bit lowercase, no separators, LF only
        start_frame(2'd1, 96'hBEEF);
        rcv("beef\012", 100, 1'b0);
        end_frame(1'b0, '0);

        // Single-nibble word
        start_frame(2'd2, 96'hA);
        rcv("A\015\012", 50, 1'b0);
        end_frame(1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
